// File: rtl/mix_seq_ctrl.sv
// Sequencer for the 32-bit XOR-mixing register: loads a seed, advances one step per
// accepted 2-bit input beat, then offers the final register value on a valid/ready port.
module mix_seq_ctrl #(
    parameter int STEP_W = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              cmd_valid,
    output logic              cmd_ready,
    input  logic [31:0]       cmd_seed,
    input  logic [STEP_W-1:0] cmd_steps,
    input  logic              din_valid,
    output logic              din_ready,
    input  logic [1:0]        din,
    output logic              res_valid,
    input  logic              res_ready,
    output logic [31:0]       res_data,
    output logic [3:0]        taps,
    output logic              busy
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_RUN,
        S_DONE
    } state_t;

    localparam logic [STEP_W-1:0] CNT_ONE = STEP_W'(1);

    state_t            state_q, state_d;
    logic [31:0]       reg_q, reg_d;
    logic [31:0]       mix;
    logic [STEP_W-1:0] cnt_q, cnt_d;
    logic              cmd_ready_q, din_ready_q, res_valid_q, busy_q;

    // One mixing step; every feedback term reads the pre-step register.
    always_comb begin
        mix[1:0] = din;
        for (int i = 2; i < 32; i++) begin
            mix[i] = reg_q[(i + 3) % 32] ^ reg_q[(i + 30) % 32]
                   ^ reg_q[(i + 4) % 16] ^ reg_q[(i + 2) % 32];
        end
    end

    // NOTE: every signal gets a default before the case so no path leaves it unassigned (no latch).
    always_comb begin
        state_d = state_q;
        reg_d   = reg_q;
        cnt_d   = cnt_q;
        case (state_q)
            S_IDLE: begin
                if (cmd_valid) begin
                    reg_d   = cmd_seed;
                    cnt_d   = cmd_steps;
                    state_d = (cmd_steps != '0) ? S_RUN : S_DONE;
                end
            end
            S_RUN: begin
                if (din_valid) begin
                    reg_d = mix;
                    cnt_d = cnt_q - CNT_ONE;
                    if (cnt_q == CNT_ONE) begin
                        state_d = S_DONE;
                    end
                end
            end
            S_DONE: begin
                if (res_ready) begin
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so all flops update together.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= S_IDLE;
            reg_q       <= '0;
            cnt_q       <= '0;
            cmd_ready_q <= 1'b1;
            din_ready_q <= 1'b0;
            res_valid_q <= 1'b0;
            busy_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            reg_q       <= reg_d;
            cnt_q       <= cnt_d;
            // Handshake outputs are flops decoded from the next state, never from inputs.
            cmd_ready_q <= (state_d == S_IDLE);
            din_ready_q <= (state_d == S_RUN);
            res_valid_q <= (state_d == S_DONE);
            busy_q      <= (state_d != S_IDLE);
        end
    end

    assign cmd_ready = cmd_ready_q;
    assign din_ready = din_ready_q;
    assign res_valid = res_valid_q;
    assign busy      = busy_q;
    assign res_data  = reg_q;
    assign taps      = {reg_q[15], reg_q[9], reg_q[5], reg_q[3]};

endmodule

// File: doc/mix_seq_ctrl.md
# mix_seq_ctrl

Sequencer for the team's 32-bit XOR-mixing register, the same feedback core used in the iCE40 packing tests. It accepts a seed-and-step-count command, loads the register, and advances it one step per accepted 2-bit input beat. It stalls the core's clock enable when input data is absent and hands the final state out on a valid/ready result port. It sits between a command source and a result consumer, and owns the mixing register outright.

## Interface
- STEP_W, 16, width of the step count field and the internal step counter.
- clk  in  1  clock.
- rst  in  1  reset, synchronous, active-high.
- cmd_valid  in  1  command offered.
- cmd_ready  out  1  command accepted when high together with cmd_valid.
- cmd_seed  in  32  initial register value.
- cmd_steps  in  STEP_W  number of mixing steps to run; 0 is legal.
- din_valid  in  1  input beat offered.
- din_ready  out  1  beat consumed when high together with din_valid.
- din  in  2  bit 0 feeds reg[0] and bit 1 feeds reg[1] on a step.
- res_valid  out  1  result available.
- res_ready  in  1  consumer takes the result.
- res_data  out  32  mixing register contents.
- taps  out  4  {reg[15], reg[9], reg[5], reg[3]}, always live.
- busy  out  1  high in any state other than IDLE.

## Operation
- States: IDLE, RUN, DONE. Encoding is free.
- IDLE:
  - cmd_ready=1.
  - On cmd_valid: reg<=cmd_seed and cnt<=cmd_steps.
  - Next state is RUN if cmd_steps!=0, otherwise DONE.
- RUN:
  - din_ready=1.
  - A step occurs on a cycle where din_valid=1; no step occurs otherwise, and reg and cnt hold.
  - Step rule: reg[0]<=din[0] and reg[1]<=din[1].
  - For i=2..31: reg[i]<=reg[(i+3)%32]^reg[(i+30)%32]^reg[(i+4)%16]^reg[(i+2)%32]. All terms are taken from pre-step values.
  - On each step, cnt<=cnt-1. The step with cnt==1 moves the FSM to DONE.
- DONE:
  - res_valid=1; res_data=reg, held stable.
  - On res_ready, go to IDLE.
  - No steps occur in DONE; din_ready=0.
- cmd_ready=0 outside IDLE. Commands offered while busy are not consumed and have no effect.
- res_data=reg in all states; it is only meaningful while res_valid=1.
- Counter: unsigned, STEP_W bits. cmd_steps=2^STEP_W-1 runs that many steps exactly, with no wrap.
- Reset, including mid-RUN or mid-DONE:
  - reg<=0, cnt<=0, state<=IDLE.
  - Any pending result is discarded.
  - The din beat presented in the reset cycle is not consumed.

## Timing
- All outputs are registered-state decodes. None depend combinationally on cmd_valid, din_valid or res_ready.
- Reset values: cmd_ready=1, din_ready=0, res_valid=0, res_data=0, taps=0, busy=0.
- Command accepted at edge E: busy=1 from E+1.
- With din_valid held high, N steps complete at edges E+1..E+N, and res_valid=1 from E+N+1.
- With steps=0, res_valid=1 from E+1 and res_data=seed.
- Each low-din_valid cycle in RUN adds exactly one cycle of latency.
- Result taken at edge F (res_valid&&res_ready): cmd_ready=1 from F+1. A new command can be accepted at edge F+1 at the earliest.
- taps follows reg with zero added latency, i.e. the same-cycle decode of the register.

## Test plan
- Reset, then seed 0x00000000, steps 5, din=00 every cycle -> res_valid at E+6, res_data=0x00000000, taps=0.
- Seed 0x00000001, steps 1, din=00 -> res_data=0x70001004 at E+2.
- Seed 0x00000000, steps 1, din=01 -> res_data=0x00000001 and taps=0000. Repeat with din=10 -> res_data=0x00000002.
- Seed 0x00000001, steps 4, with din_valid deasserted for 3 cycles after the 2nd step:
  - res_data equals the unstalled run.
  - res_valid rises 3 cycles later than unstalled.
  - cmd_valid pulsed during the run is not acknowledged.
- Steps 0 with seed 0xDEADBEEF -> res_valid at E+1 and res_data=0xDEADBEEF. Hold res_ready=0 for 4 cycles: res_data stable, cmd_ready=0. Release: IDLE next cycle.
- Start steps 10 and assert rst after 3 steps:
  - Next cycle: busy=0, res_data=0, taps=0, cmd_ready=1.
  - A new command with seed 0x00000001, steps 1, din=00 then yields 0x70001004.
